maxpool_window_buffer: RTL and testbench
========================================

Name: maxpool_window_buffer

Overview:
Downstream consumer of the PE control unit's ReLU/maxpool strobes. It accepts one ReLU output per max_fifo_en pulse and buffers one conv-output row. It assembles non-overlapping 2x2 windows and raises valid_window_maxfifo. When the control unit returns maxpool_en, it emits the window maximum. It sits between the ReLU stage and the next PE's line buffer.

Parameters:
DATA_WIDTH, 16, signed width of ReLU samples and pooled output
ROW_WIDTH, 32, conv-output pixels per row; must be even and >= 2
COL_W, $clog2(ROW_WIDTH), column counter / row-buffer address width

Ports:
clk  input  1  system clock
rst  input  1  reset. One clock; reset is asynchronous and active-low.
frame_start  input  1  synchronous clear of row/column state at channel/frame start
max_fifo_en  input  1  write strobe; relu_data valid this cycle
relu_data  input  DATA_WIDTH  signed ReLU output sample
maxpool_en  input  1  consume request for the held window
valid_window_maxfifo  output  1  a complete 2x2 window is held
pool_data  output  DATA_WIDTH  signed max of the consumed window
pool_valid  output  1  one-cycle pulse; pool_data valid
pool_col  output  COL_W-1  column index (0..ROW_WIDTH/2-1) of pool_data
pool_row_last  output  1  with pool_valid, marks the last pooled pixel of a row
overrun  output  1  sticky; a window was overwritten before consumption

Behaviour:
- Reset (rst low, async): col_cnt=0, row_odd=0, window regs=0, and all outputs 0.
- frame_start (sync) clears col_cnt, row_odd, valid_window_maxfifo and overrun. It does not clear pool_data. If max_fifo_en is asserted in the same cycle, the sample is accepted as row 0, col 0.
- Accept rule: each max_fifo_en cycle accepts relu_data at col_cnt.
  - col_cnt increments; at ROW_WIDTH-1 it wraps to 0 and row_odd toggles.
  - No backpressure; the block never stalls input.
- Even row (row_odd=0): the sample is written to row_buf[col_cnt]. Storage is registered and single-port, with one write per cycle.
- Odd row (row_odd=1), even col: the sample is held in bot_left; row_buf[col_cnt] is read into top_left.
- Odd row, odd col: the window {top_left, row_buf[col_cnt], bot_left, relu_data} is latched into win[0..3].
  - valid_window_maxfifo=1 from the next cycle.
  - win_col is latched as col_cnt>>1.
- Consume rule: maxpool_en && valid_window_maxfifo in cycle N gives, in cycle N+1:
  - pool_data = signed max of win[0..3];
  - pool_col = win_col, pool_valid=1;
  - pool_row_last = (win_col == ROW_WIDTH/2-1);
  - valid_window_maxfifo clears unless a new window is latched in cycle N.
- maxpool_en while valid_window_maxfifo=0 is ignored; there is no pool_valid.
- Simultaneous consume and new window in the same cycle: the old window is pooled and output, the new window is latched, and valid stays 1. No overrun.
- New window while valid=1 and no maxpool_en: the new window overwrites the held one, valid stays 1, and overrun is set (sticky until reset or frame_start).
- Max is a signed compare of two 2-input levels. Ties keep the lower index; the result is identical either way.
- Latency:
  - 4th window pixel in cycle N gives valid_window_maxfifo in cycle N+1.
  - With maxpool_en tied to valid, pool_valid occurs in N+2.
- Reset mid-row discards all partial state. The first sample after reset is row 0, col 0.
- The elaboration check fails if ROW_WIDTH is odd or < 2.

Decomposition:
- pe_pkg: DATA_WIDTH default, typedef pixel_t (signed logic [DATA_WIDTH-1:0]), function max2(pixel_t a, b).
- Sub-module maxpool_row_buffer: ROW_WIDTH x DATA_WIDTH registered array with write port and async read at col_cnt. It is kept separate so it can map to LUTRAM.
- The max4 tree stays inline, using max2.

Test Plan:
- ROW_WIDTH=4; row0 = 1,5,2,3; row1 = 4,0,7,6; maxpool_en = valid_window_maxfifo:
  - pool_data=5 with pool_col=0, pool_row_last=0;
  - then pool_data=7 with pool_col=1, pool_row_last=1;
  - overrun=0.
- Signed data: row0 = -3,-8; row1 = -5,-1 (ROW_WIDTH=2) -> pool_data=-1.
- Hold maxpool_en=0 for two windows (row0 = 1,2,3,4; row1 = 5,6,7,9):
  - valid stays 1 and overrun=1;
  - a later maxpool_en gives pool_data=9, then valid=0.
- Consume on the same cycle as the 4th pixel of the next window: both pool outputs appear on consecutive pulses, overrun=0, and valid remains 1 after the first consume.
- Assert rst low after 3 samples, then feed a fresh 2x4 frame: outputs match the first scenario, with no stale top-row data.
- frame_start on the same cycle as max_fifo_en with data=10 mid-row:
  - that sample becomes col 0 of row 0;
  - feeding 10,0 / 0,0 (ROW_WIDTH=2) gives pool_data=10.

Source files
------------

// File: rtl/pe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pe_pkg
//  Description : Shared pixel type and compare helper for the PE pipeline.
//  Revision    : 1.0 - initial release
// ============================================================================
package pe_pkg;

    localparam int PE_DATA_WIDTH = 16;

    typedef logic signed [PE_DATA_WIDTH-1:0] pixel_t;

    // Ties keep the first operand so the lower window index wins.
    function automatic pixel_t max2(input pixel_t a, input pixel_t b);
        return (b > a) ? b : a;
    endfunction

endpackage : pe_pkg
`default_nettype wire

// File: rtl/maxpool_row_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : maxpool_row_buffer
//  Description : One conv-output row of samples; registered write, async read.
//  Revision    : 1.0 - initial release
// ============================================================================
module maxpool_row_buffer #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 32,
    parameter int ADDR_W     = $clog2(DEPTH)
) (
    input  logic                         clk,
    input  logic                         we,
    input  logic [ADDR_W-1:0]            addr,
    input  logic signed [DATA_WIDTH-1:0] wdata,
    output logic signed [DATA_WIDTH-1:0] rdata
);

    // No reset so the array can map onto distributed RAM.
    logic signed [DATA_WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[addr] <= wdata;
        end
    end

    assign rdata = r_mem[addr];

endmodule : maxpool_row_buffer
`default_nettype wire

// File: rtl/maxpool_window_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : maxpool_window_buffer
//  Description : Collects non-overlapping 2x2 windows from a ReLU stream and
//                emits the window maximum on request.
//  Revision    : 1.0 - initial release
// ============================================================================
module maxpool_window_buffer
    import pe_pkg::*;
#(
    parameter int DATA_WIDTH = PE_DATA_WIDTH,
    parameter int ROW_WIDTH  = 32,
    parameter int COL_W      = $clog2(ROW_WIDTH),
    parameter int POOL_COL_W = (COL_W > 1) ? COL_W - 1 : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         frame_start,
    input  logic                         max_fifo_en,
    input  logic signed [DATA_WIDTH-1:0] relu_data,
    input  logic                         maxpool_en,
    output logic                         valid_window_maxfifo,
    output logic signed [DATA_WIDTH-1:0] pool_data,
    output logic                         pool_valid,
    output logic [POOL_COL_W-1:0]        pool_col,
    output logic                         pool_row_last,
    output logic                         overrun
);

    if (((ROW_WIDTH % 2) != 0) || (ROW_WIDTH < 2)) begin : g_row_width_check
        $error("maxpool_window_buffer: ROW_WIDTH must be even and >= 2");
    end

    localparam logic [COL_W-1:0]      c_last_col = COL_W'(ROW_WIDTH - 1);
    localparam logic [POOL_COL_W-1:0] c_last_win = POOL_COL_W'(ROW_WIDTH / 2 - 1);

    logic [COL_W-1:0]              r_col_cnt;
    logic                          r_row_odd;
    logic signed [DATA_WIDTH-1:0]  r_top_left;
    logic signed [DATA_WIDTH-1:0]  r_bot_left;
    logic signed [DATA_WIDTH-1:0]  r_win [4];
    logic [POOL_COL_W-1:0]         r_win_col;
    logic                          r_valid;
    logic                          r_overrun;

    logic [COL_W-1:0]              w_col;
    logic                          w_row_odd;
    logic                          w_buf_we;
    logic                          w_new_win;
    logic                          w_consume;
    logic signed [DATA_WIDTH-1:0]  w_rd;
    logic signed [DATA_WIDTH-1:0]  w_max01;
    logic signed [DATA_WIDTH-1:0]  w_max23;
    logic signed [DATA_WIDTH-1:0]  w_max;

    // frame_start takes effect in its own cycle so a coincident sample lands at row 0, col 0.
    assign w_col     = frame_start ? '0 : r_col_cnt;
    assign w_row_odd = frame_start ? 1'b0 : r_row_odd;
    assign w_buf_we  = max_fifo_en & ~w_row_odd;
    assign w_new_win = max_fifo_en & w_row_odd & w_col[0];
    assign w_consume = maxpool_en & r_valid;

    maxpool_row_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (ROW_WIDTH),
        .ADDR_W     (COL_W)
    ) u_row_buffer (
        .clk   (clk),
        .we    (w_buf_we),
        .addr  (w_col),
        .wdata (relu_data),
        .rdata (w_rd)
    );

    if (DATA_WIDTH == PE_DATA_WIDTH) begin : g_pkg_max
        assign w_max01 = max2(r_win[0], r_win[1]);
        assign w_max23 = max2(r_win[2], r_win[3]);
        assign w_max   = max2(w_max01, w_max23);
    end else begin : g_wide_max
        assign w_max01 = (r_win[1] > r_win[0]) ? r_win[1] : r_win[0];
        assign w_max23 = (r_win[3] > r_win[2]) ? r_win[3] : r_win[2];
        assign w_max   = (w_max23 > w_max01) ? w_max23 : w_max01;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_col_cnt <= '0;
            r_row_odd <= 1'b0;
        end else if (max_fifo_en) begin
            if (w_col == c_last_col) begin
                r_col_cnt <= '0;
                r_row_odd <= ~w_row_odd;
            end else begin
                r_col_cnt <= w_col + COL_W'(1);
                r_row_odd <= w_row_odd;
            end
        end else if (frame_start) begin
            r_col_cnt <= '0;
            r_row_odd <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_top_left <= '0;
            r_bot_left <= '0;
            r_win_col  <= '0;
            for (int i = 0; i < 4; i++) begin
                r_win[i] <= '0;
            end
        end else begin
            if (max_fifo_en && w_row_odd && !w_col[0]) begin
                r_bot_left <= relu_data;
                r_top_left <= w_rd;
            end
            if (w_new_win) begin
                r_win[0]  <= r_top_left;
                r_win[1]  <= w_rd;
                r_win[2]  <= r_bot_left;
                r_win[3]  <= relu_data;
                r_win_col <= POOL_COL_W'(w_col >> 1);
            end
        end
    end

    // A window that replaces an unconsumed one flags overrun.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else if (frame_start) begin
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (w_new_win) begin
                r_valid <= 1'b1;
            end else if (w_consume) begin
                r_valid <= 1'b0;
            end
            if (w_new_win && r_valid && !w_consume) begin
                r_overrun <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pool_data     <= '0;
            pool_valid    <= 1'b0;
            pool_col      <= '0;
            pool_row_last <= 1'b0;
        end else begin
            pool_valid <= w_consume;
            if (w_consume) begin
                pool_data     <= w_max;
                pool_col      <= r_win_col;
                pool_row_last <= (r_win_col == c_last_win);
            end
        end
    end

    assign valid_window_maxfifo = r_valid;
    assign overrun              = r_overrun;

endmodule : maxpool_window_buffer
`default_nettype wire

// File: tb/tb_maxpool_window_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_maxpool_window_buffer
//  Description : Self-checking bench: directed tables, corner sequences and a
//                randomized run against a frame-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_maxpool_window_buffer;

    logic clk;
    logic rst;

    logic               fs4, en4, mp4;
    logic signed [15:0] d4;
    logic               vld4, pv4, last4, ovr4;
    logic signed [15:0] pd4;
    logic [0:0]         pcol4;

    logic               fs2, en2, mp2;
    logic signed [15:0] d2;
    logic               vld2, pv2, last2, ovr2;
    logic signed [15:0] pd2;
    logic [0:0]         pcol2;

    int n_chk  = 0;
    int n_fail = 0;

    maxpool_window_buffer #(.DATA_WIDTH(16), .ROW_WIDTH(4)) u_dut4 (
        .clk                  (clk),
        .rst                  (rst),
        .frame_start          (fs4),
        .max_fifo_en          (en4),
        .relu_data            (d4),
        .maxpool_en           (mp4),
        .valid_window_maxfifo (vld4),
        .pool_data            (pd4),
        .pool_valid           (pv4),
        .pool_col             (pcol4),
        .pool_row_last        (last4),
        .overrun              (ovr4)
    );

    maxpool_window_buffer #(.DATA_WIDTH(16), .ROW_WIDTH(2)) u_dut2 (
        .clk                  (clk),
        .rst                  (rst),
        .frame_start          (fs2),
        .max_fifo_en          (en2),
        .relu_data            (d2),
        .maxpool_en           (mp2),
        .valid_window_maxfifo (vld2),
        .pool_data            (pd2),
        .pool_valid           (pv2),
        .pool_col             (pcol2),
        .pool_row_last        (last2),
        .overrun              (ovr2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit fs; bit en; int d; bit mp;
        bit pv; int pd; int col; bit last; bit vld; bit ovr;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic cyc4(input bit fs, input bit en, input int d, input bit mp);
        fs4 = fs; en4 = en; d4 = 16'(d); mp4 = mp;
        @(posedge clk); #1;
        fs4 = 1'b0; en4 = 1'b0; d4 = '0; mp4 = 1'b0;
    endtask

    task automatic cyc2(input bit fs, input bit en, input int d, input bit mp);
        fs2 = fs; en2 = en; d2 = 16'(d); mp2 = mp;
        @(posedge clk); #1;
        fs2 = 1'b0; en2 = 1'b0; d2 = '0; mp2 = 1'b0;
    endtask

    task automatic run_table(input string tag);
        for (int i = 0; i < 10; i++) begin
            cyc4(tbl[i].fs, tbl[i].en, tbl[i].d, tbl[i].mp);
            chk($sformatf("%s[%0d].valid", tag, i), vld4, tbl[i].vld);
            chk($sformatf("%s[%0d].pool_valid", tag, i), pv4, tbl[i].pv);
            chk($sformatf("%s[%0d].pool_data", tag, i), pd4, tbl[i].pd);
            chk($sformatf("%s[%0d].overrun", tag, i), ovr4, tbl[i].ovr);
            if (tbl[i].pv) begin
                chk($sformatf("%s[%0d].pool_col", tag, i), pcol4, tbl[i].col);
                chk($sformatf("%s[%0d].row_last", tag, i), last4, tbl[i].last);
            end
        end
    endtask

    // Reference model for ROW_WIDTH=4: keeps the two most recent rows as
    // a plain image and evaluates windows when their last pixel arrives.
    int m_n, m_max, m_col, e_pd, e_col;
    int m_img [2][4];
    bit m_valid, m_ovr, e_pv, e_last;

    task automatic model_reset();
        m_n = 0; m_valid = 0; m_ovr = 0; m_max = 0; m_col = 0;
        e_pv = 0; e_pd = 0; e_col = 0; e_last = 0;
    endtask

    task automatic model_step(input bit fs, input bit en, input int d, input bit mp);
        bit consume;
        bit neww;
        int r, c, mx;
        consume = mp && m_valid;
        neww    = 0;
        e_pv    = consume;
        if (consume) begin
            e_pd   = m_max;
            e_col  = m_col;
            e_last = (m_col == 1);
        end
        if (fs) begin
            m_n = 0; m_valid = 0; m_ovr = 0;
        end
        if (en) begin
            r = (m_n / 4) % 2;
            c = m_n % 4;
            m_img[r][c] = d;
            if (r == 1 && (c % 2) == 1) begin
                mx = m_img[0][c-1];
                if (m_img[0][c]   > mx) mx = m_img[0][c];
                if (m_img[1][c-1] > mx) mx = m_img[1][c-1];
                if (m_img[1][c]   > mx) mx = m_img[1][c];
                neww = 1;
                if (m_valid && !consume) m_ovr = 1;
                m_max = mx;
                m_col = c / 2;
            end
            m_n = (m_n + 1) % 8;
        end
        if (neww) m_valid = 1;
        else if (consume) m_valid = 0;
    endtask

    initial begin
        logic signed [15:0] rd;
        bit fs, en, mp;

        //                fs en  d  mp | pv pd col last vld ovr
        tbl[0] = '{0, 1, 1, 0,  0, 0, 0, 0, 0, 0};
        tbl[1] = '{0, 1, 5, 0,  0, 0, 0, 0, 0, 0};
        tbl[2] = '{0, 1, 2, 0,  0, 0, 0, 0, 0, 0};
        tbl[3] = '{0, 1, 3, 0,  0, 0, 0, 0, 0, 0};
        tbl[4] = '{0, 1, 4, 0,  0, 0, 0, 0, 0, 0};
        tbl[5] = '{0, 1, 0, 0,  0, 0, 0, 0, 1, 0};
        tbl[6] = '{0, 1, 7, 1,  1, 5, 0, 0, 0, 0};
        tbl[7] = '{0, 1, 6, 0,  0, 5, 0, 0, 1, 0};
        tbl[8] = '{0, 0, 0, 1,  1, 7, 1, 1, 0, 0};
        tbl[9] = '{0, 0, 0, 0,  0, 7, 0, 0, 0, 0};

        rst = 1'b0;
        fs4 = 0; en4 = 0; d4 = '0; mp4 = 0;
        fs2 = 0; en2 = 0; d2 = '0; mp2 = 0;
        @(posedge clk); #1;
        chk("reset.valid", vld4, 0);
        chk("reset.pool_valid", pv4, 0);
        chk("reset.pool_data", pd4, 0);
        chk("reset.overrun", ovr4, 0);
        chk("reset2.valid", vld2, 0);
        rst = 1'b1;
        @(posedge clk); #1;

        run_table("basic");

        // Two windows with no consume: second overwrites the first.
        cyc4(1, 0, 0, 0);
        foreach (tbl[i]) if (i < 6) cyc4(0, 1, i + 1, 0);
        chk("ovr.valid_first", vld4, 1);
        chk("ovr.overrun_first", ovr4, 0);
        cyc4(0, 1, 7, 0);
        cyc4(0, 1, 9, 0);
        chk("ovr.valid_held", vld4, 1);
        chk("ovr.overrun_set", ovr4, 1);
        cyc4(0, 0, 0, 1);
        chk("ovr.pool_valid", pv4, 1);
        chk("ovr.pool_data", pd4, 9);
        chk("ovr.pool_col", pcol4, 1);
        chk("ovr.row_last", last4, 1);
        chk("ovr.valid_cleared", vld4, 0);
        chk("ovr.overrun_sticky", ovr4, 1);
        cyc4(1, 0, 0, 0);
        chk("ovr.frame_start_clear", ovr4, 0);

        // Consume coincides with the last pixel of the next window.
        cyc4(0, 1, 8, 0); cyc4(0, 1, 1, 0); cyc4(0, 1, 2, 0); cyc4(0, 1, 3, 0);
        cyc4(0, 1, 4, 0); cyc4(0, 1, 5, 0); cyc4(0, 1, 6, 0);
        chk("sim.valid_pre", vld4, 1);
        cyc4(0, 1, 0, 1);
        chk("sim.pool_valid_a", pv4, 1);
        chk("sim.pool_data_a", pd4, 8);
        chk("sim.pool_col_a", pcol4, 0);
        chk("sim.valid_kept", vld4, 1);
        chk("sim.overrun_a", ovr4, 0);
        cyc4(0, 0, 0, 1);
        chk("sim.pool_valid_b", pv4, 1);
        chk("sim.pool_data_b", pd4, 6);
        chk("sim.pool_col_b", pcol4, 1);
        chk("sim.row_last_b", last4, 1);
        chk("sim.valid_after", vld4, 0);
        chk("sim.overrun_b", ovr4, 0);

        // Asynchronous reset mid-row, then a fresh frame.
        cyc4(0, 1, 9, 0); cyc4(0, 1, 9, 0); cyc4(0, 1, 9, 0);
        rst = 1'b0;
        #2;
        chk("arst.pool_data_async", pd4, 0);
        chk("arst.valid_async", vld4, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        run_table("after_rst");

        // Signed window, ROW_WIDTH=2.
        cyc2(0, 1, -3, 0); cyc2(0, 1, -8, 0); cyc2(0, 1, -5, 0); cyc2(0, 1, -1, 0);
        chk("signed.valid", vld2, 1);
        cyc2(0, 0, 0, 1);
        chk("signed.pool_valid", pv2, 1);
        chk("signed.pool_data", pd2, -1);
        chk("signed.pool_col", pcol2, 0);
        chk("signed.row_last", last2, 1);
        chk("signed.valid_after", vld2, 0);

        // frame_start with a coincident sample restarts at row 0, col 0.
        cyc2(0, 1, 20, 0);
        cyc2(1, 1, 10, 0);
        cyc2(0, 1, 0, 0); cyc2(0, 1, 0, 0);
        chk("fs.valid_early", vld2, 0);
        cyc2(0, 1, 0, 0);
        chk("fs.valid", vld2, 1);
        cyc2(0, 0, 0, 1);
        chk("fs.pool_valid", pv2, 1);
        chk("fs.pool_data", pd2, 10);
        chk("fs.overrun", ovr2, 0);

        // Randomized run against the reference model.
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        model_reset();
        for (int k = 0; k < 600; k++) begin
            fs = ($urandom_range(0, 59) == 0);
            en = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0) rd = 16'($urandom_range(0, 3)) - 16'sd1;
            else rd = 16'($urandom);
            mp = (k % 200 < 100) ? vld4 : ($urandom_range(0, 3) == 0);
            model_step(fs, en, int'(rd), mp);
            cyc4(fs, en, int'(rd), mp);
            chk($sformatf("rnd[%0d].valid", k), vld4, m_valid);
            chk($sformatf("rnd[%0d].pool_valid", k), pv4, e_pv);
            chk($sformatf("rnd[%0d].pool_data", k), pd4, e_pd);
            chk($sformatf("rnd[%0d].overrun", k), ovr4, m_ovr);
            if (e_pv) begin
                chk($sformatf("rnd[%0d].pool_col", k), pcol4, e_col);
                chk($sformatf("rnd[%0d].row_last", k), last4, e_last);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_maxpool_window_buffer
`default_nettype wire
